// File: rtl/aud_recorder_mc.sv
// aud_recorder_mc: I2S ADC capture into SRAM write strobes (BCLK domain).
// Ports: i_clk/i_rst_n, I2S i_lrc/i_data, controls i_start/i_pause/i_stop/i_ch_sel,
// SRAM write o_address/o_data/o_valid, status o_len/o_full/o_busy.
module aud_recorder_mc #(
  parameter int     DATA_W   = 16,
  parameter int     ADDR_W   = 20,
  parameter int     NUM_CH   = 1,
  parameter longint MAX_ADDR = (64'd1 << ADDR_W) - 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_data,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_ch_sel,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic [ADDR_W:0]   o_len,
  output logic              o_full,
  output logic              o_busy
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [ADDR_W:0] LP_MAX =
    (ADDR_W+1)'(MAX_ADDR);
  localparam bit LP_ST = (NUM_CH == 2);

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_REC, S_PAUSE
  } state_t;

  state_t            r_state;
  logic              r_lrc_d;
  logic              r_ch;
  logic              r_act;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-2:0] r_sh;
  logic [ADDR_W:0]   r_wp;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic [ADDR_W:0]   r_len;
  logic              r_full;
  logic              r_busy;

  logic              w_edge;
  logic              w_start_slot;
  logic              w_want;
  logic              w_odd;
  logic [ADDR_W:0]   w_wp_al;
  logic [DATA_W-1:0] w_word;
  logic              w_last;

  assign w_edge = i_lrc ^ r_lrc_d;
  // stereo always starts on a left slot so pairs land on even/odd
  assign w_start_slot = LP_ST ? ~i_lrc
                              : (i_lrc == r_ch);
  assign w_want = LP_ST | (i_lrc == r_ch);
  // drop an orphan left word so a stereo pair never splits
  assign w_odd   = LP_ST & r_wp[0];
  assign w_wp_al = r_wp - {{ADDR_W{1'b0}}, w_odd};
  assign w_word  = {r_sh, i_data};
  assign w_last  = (r_cnt == CW'(DATA_W-1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_lrc_d <= 1'b0;
      r_ch    <= 1'b0;
      r_act   <= 1'b0;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_wp    <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_len   <= '0;
      r_full  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_lrc_d <= i_lrc;
      r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start && !i_stop && !i_pause) begin
            r_state <= S_WAIT;
            r_busy  <= 1'b1;
            r_wp    <= '0;
            r_len   <= '0;
            r_full  <= 1'b0;
            r_ch    <= i_ch_sel;
            r_act   <= 1'b0;
          end
        end
        default: begin
          if (i_stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_act   <= 1'b0;
            r_wp    <= w_wp_al;
            r_len   <= w_wp_al;
          end else if (i_pause) begin
            if (r_state != S_PAUSE) begin
              r_state <= S_PAUSE;
              r_act   <= 1'b0;
              r_wp    <= w_wp_al;
              r_len   <= w_wp_al;
            end
          end else if (i_start && r_state == S_PAUSE) begin
            r_state <= S_WAIT;
          end else if (r_state == S_WAIT) begin
            if (w_edge && w_start_slot) begin
              r_state <= S_REC;
              r_act   <= 1'b1;
              r_cnt   <= '0;
            end
          end else if (r_state == S_REC) begin
            if (w_edge) begin
              r_act <= w_want;
              r_cnt <= '0;
            end else if (r_act) begin
              r_sh  <= w_word[DATA_W-2:0];
              r_cnt <= r_cnt + 1'b1;
              if (w_last) begin
                r_act   <= 1'b0;
                r_data  <= w_word;
                r_addr  <= r_wp[ADDR_W-1:0];
                r_valid <= 1'b1;
                r_wp    <= r_wp + 1'b1;
                r_len   <= r_wp + 1'b1;
                if (r_wp == LP_MAX) begin
                  r_full  <= 1'b1;
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                end
              end
            end
          end
        end
      endcase
    end
  end

  assign o_address = r_addr;
  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_len     = r_len;
  assign o_full    = r_full;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_aud_recorder_mc.sv
// tb_aud_recorder_mc: three recorder configurations on one I2S stream,
// slot-level reference model feeding per-instance strobe scoreboards.
module tb_aud_recorder_mc;

  localparam int IDLE = 0;
  localparam int WAIT = 1;
  localparam int REC  = 2;
  localparam int PAU  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lrc = 1'b0;
  logic dat = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic stop = 1'b0;
  logic chsel = 1'b0;

  always #5 clk = ~clk;

  logic [3:0]  a0;
  logic [15:0] d0;
  logic        v0;
  logic [4:0]  l0;
  logic        f0, b0;
  logic [7:0]  a1;
  logic [15:0] d1;
  logic        v1;
  logic [8:0]  l1;
  logic        f1, b1;
  logic [5:0]  a2;
  logic [23:0] d2;
  logic        v2;
  logic [6:0]  l2;
  logic        f2, b2;

  // mono 16-bit, tiny memory that fills
  aud_recorder_mc #(
    .DATA_W(16), .ADDR_W(4),
    .NUM_CH(1), .MAX_ADDR(5)
  ) u0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_lrc(lrc), .i_data(dat),
    .i_start(start), .i_pause(pause),
    .i_stop(stop), .i_ch_sel(chsel),
    .o_address(a0), .o_data(d0),
    .o_valid(v0), .o_len(l0),
    .o_full(f0), .o_busy(b0)
  );

  // stereo 16-bit
  aud_recorder_mc #(
    .DATA_W(16), .ADDR_W(8),
    .NUM_CH(2), .MAX_ADDR(255)
  ) u1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_lrc(lrc), .i_data(dat),
    .i_start(start), .i_pause(pause),
    .i_stop(stop), .i_ch_sel(chsel),
    .o_address(a1), .o_data(d1),
    .o_valid(v1), .o_len(l1),
    .o_full(f1), .o_busy(b1)
  );

  // mono 24-bit
  aud_recorder_mc #(
    .DATA_W(24), .ADDR_W(6),
    .NUM_CH(1), .MAX_ADDR(63)
  ) u2 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_lrc(lrc), .i_data(dat),
    .i_start(start), .i_pause(pause),
    .i_stop(stop), .i_ch_sel(chsel),
    .o_address(a2), .o_data(d2),
    .o_valid(v2), .o_len(l2),
    .o_full(f2), .o_busy(b2)
  );

  int errs = 0;
  int checks = 0;

  int m_st[3];
  int m_wp[3];
  bit m_full[3];
  bit m_ch[3];

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] q2[$];

  function automatic int dw(input int d);
    return (d == 2) ? 24 : 16;
  endfunction

  function automatic bit is_st(input int d);
    return d == 1;
  endfunction

  function automatic int maxa(input int d);
    case (d)
      0: return 5;
      1: return 255;
      default: return 63;
    endcase
  endfunction

  function automatic void get_out(
    input  int d,
    output logic [31:0] a,
    output logic [31:0] dd,
    output logic [31:0] ln,
    output logic v,
    output logic f,
    output logic b
  );
    case (d)
      0: begin
        a = 32'(a0); dd = 32'(d0); ln = 32'(l0);
        v = v0; f = f0; b = b0;
      end
      1: begin
        a = 32'(a1); dd = 32'(d1); ln = 32'(l1);
        v = v1; f = f1; b = b1;
      end
      default: begin
        a = 32'(a2); dd = 32'(d2); ln = 32'(l2);
        v = v2; f = f2; b = b2;
      end
    endcase
  endfunction

  function automatic int q_size(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic q_push(input int d, input logic [63:0] x);
    case (d)
      0: q0.push_back(x);
      1: q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endtask

  task automatic q_pop(input int d, output logic [63:0] x);
    case (d)
      0: x = q0.pop_front();
      1: x = q1.pop_front();
      default: x = q2.pop_front();
    endcase
  endtask

  task automatic chk(
    input string nm, input int d,
    input logic [31:0] act, input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d: got %0h, required %0h",
               nm, d, act, exp);
    end
  endtask

  // ---------------- reference model (one I2S slot at a time) ----------
  // control kinds: 0 none, 1 stop, 2 pause, 3 start
  function automatic int resolve(input int d, input logic [2:0] m);
    if (m[2]) return (m_st[d] != IDLE) ? 1 : 0;
    if (m[1]) return (m_st[d] == WAIT || m_st[d] == REC) ? 2 : 0;
    if (m[0]) return (m_st[d] == IDLE || m_st[d] == PAU) ? 3 : 0;
    return 0;
  endfunction

  task automatic apply(input int d, input int k, input bit cs);
    if (k == 3) begin
      if (m_st[d] == IDLE) begin
        m_wp[d] = 0;
        m_full[d] = 1'b0;
        m_ch[d] = cs;
      end
      m_st[d] = WAIT;
    end else if (k != 0) begin
      if (is_st(d) && (m_wp[d] % 2 == 1)) m_wp[d]--;
      m_st[d] = (k == 1) ? IDLE : PAU;
    end
  endtask

  // slot of channel ch carrying v (MSB first); control mask m at cycle c
  // (cycle 0 = frame edge, cycle k samples bit k-1 of the word).
  task automatic model_slot(
    input int d, input bit ch, input logic [31:0] v,
    input logic [2:0] m, input int c, input bit cs
  );
    bit cap, used, skip;
    int k;
    bit want_ch;
    logic [31:0] w;
    cap = 0; used = 0; skip = 0;
    if (m != 0 && c == 0) begin
      used = 1;
      k = resolve(d, m);
      if (k != 0) begin
        apply(d, k, cs);
        skip = 1;
      end
    end
    if (!skip) begin
      want_ch = is_st(d) ? 1'b0 : m_ch[d];
      if (m_st[d] == WAIT && ch == want_ch) begin
        m_st[d] = REC;
        cap = 1;
      end else if (m_st[d] == REC) begin
        cap = is_st(d) || (ch == m_ch[d]);
      end
    end
    // pulse lands before (or on) the last bit: control wins
    if (m != 0 && !used && (!cap || c <= dw(d))) begin
      used = 1;
      k = resolve(d, m);
      if (k != 0) begin
        apply(d, k, cs);
        cap = 0;
      end
    end
    if (cap) begin
      w = v >> (32 - dw(d));
      q_push(d, {32'(m_wp[d]), w});
      if (m_wp[d] == maxa(d)) begin
        m_full[d] = 1'b1;
        m_st[d] = IDLE;
      end
      m_wp[d]++;
    end
    if (m != 0 && !used) begin
      k = resolve(d, m);
      apply(d, k, cs);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_st[d] = IDLE;
      m_wp[d] = 0;
      m_full[d] = 1'b0;
      m_ch[d] = 1'b0;
    end
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  task automatic chk_reset_outs();
    logic [31:0] a, dd, ln;
    logic v, f, b;
    for (int d = 0; d < 3; d++) begin
      get_out(d, a, dd, ln, v, f, b);
      chk("rst_addr", d, a, 32'h0);
      chk("rst_data", d, dd, 32'h0);
      chk("rst_valid", d, 32'(v), 32'h0);
      chk("rst_len", d, ln, 32'h0);
      chk("rst_full", d, 32'(f), 32'h0);
      chk("rst_busy", d, 32'(b), 32'h0);
    end
  endtask

  // ---------------- strobe monitor ----------------
  logic [31:0] mn_a, mn_d, mn_l;
  logic        mn_v, mn_f, mn_b;
  logic [63:0] mn_e;

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      get_out(d, mn_a, mn_d, mn_l, mn_v, mn_f, mn_b);
      if (rst_n && mn_v) begin
        checks++;
        if (q_size(d) == 0) begin
          errs++;
          $display("FAIL strobe dut%0d: unexpected addr=%0h data=%0h, required none",
                   d, mn_a, mn_d);
        end else begin
          q_pop(d, mn_e);
          if ({mn_a, mn_d} !== mn_e) begin
            errs++;
            $display("FAIL strobe dut%0d: got addr=%0h data=%0h, required addr=%0h data=%0h",
                     d, mn_a, mn_d, mn_e[63:32], mn_e[31:0]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // entered and left on a falling clock edge; 32 BCLKs per slot
  task automatic do_slot(
    input bit ch, input logic [31:0] v,
    input logic [2:0] m, input int c,
    input bit cs, input int rc
  );
    logic [31:0] a, dd, ln;
    logic f, b, vv;
    for (int d = 0; d < 3; d++) model_slot(d, ch, v, m, c, cs);
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      lrc = ch;
      dat = (i == 0) ? 1'b0 : v[32-i];
      chsel = cs;
      {stop, pause, start} = (i == c) ? m : 3'b000;
      if (i == rc) begin
        #2 rst_n = 1'b0;
        #1 chk_reset_outs();
        model_reset();
      end
      if (rc >= 0 && i == rc + 1) begin
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    {stop, pause, start} = 3'b000;
    for (int d = 0; d < 3; d++) begin
      get_out(d, a, dd, ln, vv, f, b);
      chk("len", d, ln, 32'(m_wp[d]));
      chk("full", d, 32'(f), 32'(m_full[d]));
      chk("busy", d, 32'(b), 32'(m_st[d] != IDLE));
    end
  endtask

  logic [31:0] vals [8];

  initial begin
    logic [31:0] v;
    logic [2:0]  m;
    logic [2:0]  picks [4];
    int c, rc, sc;
    bit cs;

    vals[0] = 32'h6A4C_5A5A;
    vals[1] = 32'h1234_A5A5;
    vals[2] = 32'hF2CF_0F0F;
    vals[3] = 32'hAAAA_F0F0;
    vals[4] = 32'hF64F_3C3C;
    vals[5] = 32'hABCD_EF12;
    vals[6] = 32'h83C1_C3C3;
    vals[7] = 32'h9C58_7777;
    picks[0] = 3'b100;
    picks[1] = 3'b010;
    picks[2] = 3'b001;
    picks[3] = 3'b101;

    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_outs();
    rst_n = 1'b1;

    for (int s = 0; s < 36; s++) begin
      v = vals[s % 8];
      m = 3'b000;
      c = 0;
      cs = 1'b0;
      rc = -1;
      case (s)
        1:  begin m = 3'b001; c = 10; end
        6:  begin m = 3'b010; c = 5; end
        10: begin m = 3'b001; c = 3; end
        14: begin m = 3'b100; c = 28; end
        16: begin m = 3'b101; c = 4; end
        18: begin m = 3'b001; c = 0; cs = 1'b1; end
        32: begin m = 3'b001; c = 20; cs = 1'b1; end
        34: rc = 6;
        default: ;
      endcase
      do_slot(s[0], v, m, c, cs, rc);
    end

    sc = 36;
    for (int s = 0; s < 200; s++) begin
      v = $urandom;
      m = 3'b000;
      c = 0;
      cs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) begin
        m = picks[$urandom_range(0, 3)];
        c = $urandom_range(0, 31);
      end
      do_slot(sc[0], v, m, c, cs, -1);
      sc++;
    end

    repeat (4) @(negedge clk);
    for (int d = 0; d < 3; d++)
      chk("pending", d, 32'(q_size(d)), 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/aud_recorder_mc.md
Name: aud_recorder_mc

Overview:
Parametrised successor to the single-channel 16-bit I2S recorder. It deserialises I2S audio from the codec ADC into DATA_W-bit words and emits one write strobe per word with an incrementing SRAM address. It adds stereo capture (left/right interleaved) and a runtime mono channel select. It also adds a length/full indication and pause/resume with frame realignment. The block sits between the codec I2S pins and the SRAM write port, in the BCLK domain.

Parameters:
DATA_W, 16, sample width in bits (8..32)
ADDR_W, 20, SRAM address width
NUM_CH, 1, 1 = mono (channel chosen by i_ch_sel), 2 = stereo interleaved (L at even, R at odd address)
MAX_ADDR, 2**ADDR_W-1, last writable address; must be odd when NUM_CH=2

Ports:
i_clk  in  1  codec BCLK; all logic on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_lrc  in  1  I2S word select; 0 = left, 1 = right
i_data  in  1  I2S serial data, MSB first
i_start  in  1  1-cycle pulse: start a new recording (IDLE) or resume (PAUSE)
i_pause  in  1  1-cycle pulse: pause recording
i_stop  in  1  1-cycle pulse: end recording
i_ch_sel  in  1  mono only: 0 = record left, 1 = record right; sampled on i_start
o_address  out  ADDR_W  address of the word on o_data
o_data  out  DATA_W  captured sample
o_valid  out  1  1-cycle write strobe
o_len  out  ADDR_W+1  number of words committed in the current/last recording
o_full  out  1  set when MAX_ADDR has been written
o_busy  out  1  high in WAIT_FRAME, RECORD and PAUSE

Behaviour:
- Reset values: o_address=0, o_data=0, o_valid=0, o_len=0, o_full=0, o_busy=0; state=IDLE; internal write pointer wp=0.
- lrc_d registers i_lrc on every edge. A frame edge is detected when i_lrc != lrc_d.
- Bit timing follows I2S with a 1-BCLK delay: the MSB is sampled on the edge after the frame-edge edge, then DATA_W-1 further bits are sampled on consecutive edges. Bits beyond DATA_W in a slot are ignored.
- Word commit occurs on the edge that samples the LSB: o_data<=word, o_address<=wp, o_valid=1 for that one cycle, wp<=wp+1, o_len<=wp+1.
- States:
  - IDLE: i_start goes to WAIT_FRAME; wp=0, o_len=0, o_full=0; the mono channel is latched from i_ch_sel.
  - WAIT_FRAME: waits for a frame edge into the capture-start slot, then goes to RECORD. The capture-start slot is the left slot (falling i_lrc) in stereo, or the selected channel's slot in mono. No partial word is ever captured.
  - RECORD: captures words. In mono, only slots of the latched channel are captured. In stereo, L and R are captured alternately.
  - PAUSE: no capture. i_start goes to WAIT_FRAME (realign); wp is kept.
- Control priority: i_stop > i_pause > i_start. The same-cycle combination stop+start in IDLE starts nothing.
- i_pause in RECORD or WAIT_FRAME goes to PAUSE. i_stop in any non-IDLE state goes to IDLE. In both cases an in-progress partial word is discarded (no o_valid).
- Stereo pair integrity: if pause/stop occurs with wp odd (L committed, R not), wp and o_len are decremented by 1. The orphan L word is overwritten on resume.
- Full: when a commit writes address MAX_ADDR, o_full=1 on that same edge and the next state is IDLE. wp does not wrap. o_full clears only on the next i_start from IDLE or on reset.
- Pulses ignored:
  - i_start in RECORD or WAIT_FRAME.
  - i_pause in PAUSE or IDLE.
- A commit edge coinciding with i_stop/i_pause: the control wins and the word is discarded.
- Asynchronous reset mid-recording clears everything immediately; no strobe is emitted.

Test Plan:
- Mono-left, DATA_W=16: start, drive L words 16'hF2CF, 16'hF64F and R words 16'hAAAA → exactly 2 strobes with (addr 0, F2CF) and (addr 1, F64F); o_len=2.
- Stereo NUM_CH=2: start mid right slot, drive L/R pairs (83C1, 9C58), (6A4C, 1234) → the first partial R slot is skipped; strobes at addresses 0..3 carry 83C1, 9C58, 6A4C, 1234.
- Pause at bit 5 of word 2, then resume after 3 frames: word 2 is discarded; the next strobe is at address 1 (mono), at the first full selected slot after resume.
- Stereo stop after L committed at address 2: o_len drops from 3 to 2; state IDLE; no further strobes.
- Full, ADDR_W=4, MAX_ADDR=5, mono: 6 commits → o_full=1 with the 6th strobe at address 5; the 7th word produces no strobe; i_start clears o_full and o_len.
- DATA_W=24, plus async reset asserted mid-word: a 24-bit word 24'hABCDEF is captured correctly; reset mid-word leaves all outputs 0 and no strobe.
